fifo_vr_pkt: RTL and testbench
==============================

FIFO_VR_PKT -- requirements
Module: fifo_vr_pkt

Interface
REQ-001 Parameter DEPTH, default 8: number of FIFO rows; power of two, at least 2.
REQ-002 Parameter DATA_W, default 32: payload width in bits, excluding the last flag.
REQ-003 Parameter PKT_MODE, default 0: 0 = cut-through, 1 = store-and-forward on data_in_last.
REQ-004 Parameter AFULL_LVL, default DEPTH-1: almost-full threshold, in rows.
REQ-005 Parameter AEMPTY_LVL, default 1: almost-empty threshold, in rows.
REQ-006 Local constant CNT_W = clog2(DEPTH)+1.
REQ-007 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-008 Port sync_rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 Port en, input, 1 bit: block enable.
REQ-010 Port data_in, input, DATA_W bits: write payload.
REQ-011 Port data_in_last, input, 1 bit: marks the final word of a packet.
REQ-012 Port data_in_valid, input, 1 bit: write request.
REQ-013 Port data_in_ready, output, 1 bit: write accept.
REQ-014 Port data_out, output, DATA_W bits: read payload.
REQ-015 Port data_out_last, output, 1 bit: last flag of the head word.
REQ-016 Port data_out_valid, output, 1 bit: read data available.
REQ-017 Port data_out_ready, input, 1 bit: consumer accept.
REQ-018 Port status_count, output, CNT_W bits: rows occupied.
REQ-019 Port status_pkt_count, output, CNT_W bits: complete packets held.
REQ-020 Ports status_full, status_empty, status_afull, status_aempty: outputs, 1 bit each.

Function
REQ-021 A write occurs when data_in_valid and data_in_ready are both high; a read occurs when data_out_valid and data_out_ready are both high.
REQ-022 data_in_ready SHALL be en AND (count < DEPTH), decoded from registered state only, with no combinational path from any input except en.
REQ-023 A write stores {data_in, data_in_last} at wr_ptr and increments wr_ptr; pointers are CNT_W bits and wrap modulo 2*DEPTH; the row index is the low clog2(DEPTH) bits.
REQ-024 data_out and data_out_last SHALL be a combinational read of the row at rd_ptr; a read increments rd_ptr.
REQ-025 count SHALL equal wr_ptr - rd_ptr modulo 2^CNT_W; a simultaneous write and read leaves count unchanged.
REQ-026 Write-to-output latency is 1 cycle: a word written into an empty FIFO is valid on the next cycle; there is no same-cycle fall-through.
REQ-027 When PKT_MODE=0, data_out_valid SHALL be en AND (count > 0).
REQ-028 When PKT_MODE=1, data_out_valid SHALL be en AND (count > 0) AND (pkt_count > 0 OR count == DEPTH).
- The count == DEPTH term is a deadlock fallback: a packet longer than DEPTH streams in cut-through.
REQ-029 pkt_count SHALL increment on a write with last=1 and decrement on a read with last=1; when both occur in the same cycle it is unchanged; it is maintained in both modes.
REQ-030 Status flags are registered-state decodes:
- full = (count == DEPTH)
- empty = (count == 0)
- afull = (count >= AFULL_LVL)
- aempty = (count <= AEMPTY_LVL)
REQ-031 With en low, data_in_ready and data_out_valid SHALL be low and pointers and memory SHALL hold.
REQ-032 When full, a write is not accepted even if a read occurs in the same cycle; data_in_ready rises on the cycle after that read.
REQ-033 Write with data_in_valid high and data_in_ready low: no state change. Read with data_out_valid low: no state change.

Reset
REQ-034 On a clk edge with sync_rst high, wr_ptr, rd_ptr, and pkt_count SHALL clear to 0; this overrides en and any in-flight handshake.
REQ-035 On that same edge, all memory rows SHALL clear to 0.
REQ-036 After reset, output values: data_in_ready = en, data_out_valid = 0, data_out = 0, data_out_last = 0, status_count = 0, status_pkt_count = 0, empty = 1, aempty = 1, full = 0, afull = 0.
REQ-037 A partially written packet is discarded by reset mid-packet.

Structure
REQ-038 A shared package fifo_pkg SHALL hold the clog2-based CNT_W helper function and the PKT_MODE enumerators (FIFO_CUT_THROUGH, FIFO_STORE_FWD).
REQ-039 One sub-module, fifo_vr_ptr, SHALL implement the pointer, count, and pkt_count logic; storage and the output decode remain in fifo_vr_pkt.

Verification
REQ-040 Fill test (DEPTH=4, PKT_MODE=0): write 5 words with consumer ready low.
- Words 1-4 accepted; data_in_ready low after the 4th.
- full=1, status_count=4.
- Draining returns the words in order.
REQ-041 Concurrent test: at count=2, hold valid and ready high for 10 cycles.
- count stays 2 throughout.
- Data order is preserved.
REQ-042 Store-and-forward test (PKT_MODE=1): write a 3-word packet with last on word 3.
- data_out_valid stays low until the cycle after word 3 is written.
- status_pkt_count = 1 at that point.
REQ-043 Oversize packet test (PKT_MODE=1, DEPTH=4): write a 6-word packet.
- At count=4, data_out_valid rises.
- All 6 words emerge in order.
- pkt_count is 0 at the end.
REQ-044 Mid-stream reset test: assert sync_rst at count=3, mid-packet.
- Next cycle: count=0, data_out_valid=0, pkt_count=0.
- A following 1-word packet passes intact.
REQ-045 Enable test: drop en at count=2.
- data_in_ready=0 and data_out_valid=0.
- count is held.
- Re-raising en resumes with the same data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the packet-aware valid/ready FIFO.
package fifo_pkg;

  // Packet handling mode selected by the PKT_MODE parameter.
  typedef enum logic {
    FIFO_CUT_THROUGH = 1'b0,
    FIFO_STORE_FWD   = 1'b1
  } fifo_mode_e;

  // Pointer/count width: one extra bit beyond the row index, so that
  // full and empty can be told apart.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_vr_pkt_if.sv
// Write and read valid/ready channels of the packet FIFO.
interface fifo_vr_pkt_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_in;
  logic              data_in_last;
  logic              data_in_valid;
  logic              data_in_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_out_last;
  logic              data_out_valid;
  logic              data_out_ready;

  // Producer/consumer side.
  modport master (
    output data_in, data_in_last, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_last, data_out_valid
  );

  // FIFO side.
  modport slave (
    input  data_in, data_in_last, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_last, data_out_valid
  );
endinterface

// File: rtl/fifo_vr_ptr.sv
// Read/write pointers, occupancy and complete-packet count of the FIFO.
module fifo_vr_ptr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             wr_fire,
  input  logic             wr_last,
  input  logic             rd_fire,
  input  logic             rd_last,
  output logic [CNT_W-2:0] wr_idx,
  output logic [CNT_W-2:0] rd_idx,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] pkt_count
);

  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  // Advance pointers on handshakes; track packets entering and leaving.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + CNT_W'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + CNT_W'(1);
    case ({wr_fire && wr_last, rd_fire && rd_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Control state register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Pointers wrap at 2*DEPTH, so the difference is the occupancy.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign pkt_count = pkt_cnt_q;
  assign wr_idx    = wr_ptr_q[CNT_W-2:0];
  assign rd_idx    = rd_ptr_q[CNT_W-2:0];

endmodule

// File: rtl/fifo_vr_pkt.sv
// Valid/ready FIFO with optional store-and-forward on packet boundaries.
// Output data is a combinational read of the head row; flags and the
// handshake outputs decode registered state (and en) only.
module fifo_vr_pkt
  import fifo_pkg::*;
#(
  parameter  int DEPTH      = 8,
  parameter  int DATA_W     = 32,
  parameter  int PKT_MODE   = 0,
  parameter  int AFULL_LVL  = DEPTH - 1,
  parameter  int AEMPTY_LVL = 1,
  localparam int CNT_W      = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             en,
  fifo_vr_pkt_if.slave     bus,
  output logic [CNT_W-1:0] status_count,
  output logic [CNT_W-1:0] status_pkt_count,
  output logic             status_full,
  output logic             status_empty,
  output logic             status_afull,
  output logic             status_aempty
);

  localparam int               IDX_W   = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Each row holds {payload, last}.
  typedef logic [DATA_W:0] row_t;

  row_t             mem_q [DEPTH];
  row_t             mem_d [DEPTH];
  row_t             head;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [CNT_W-1:0] count, pkt_count;
  logic             in_ready, out_valid;
  logic             wr_fire, rd_fire;

  // Handshake decode: only en reaches the outputs combinationally.
  always_comb begin
    in_ready  = en && (count < DEPTH_C);
    out_valid = en && (count != '0);
    // A packet longer than the FIFO could never complete, so a full
    // FIFO releases its head in cut-through fashion.
    if (PKT_MODE == int'(FIFO_STORE_FWD))
      out_valid = out_valid && ((pkt_count != '0) || (count == DEPTH_C));
  end

  assign wr_fire = bus.data_in_valid && in_ready;
  assign rd_fire = out_valid && bus.data_out_ready;
  assign head    = mem_q[rd_idx];

  fifo_vr_ptr #(
    .CNT_W (CNT_W)
  ) u_ptr (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .wr_fire   (wr_fire),
    .wr_last   (bus.data_in_last),
    .rd_fire   (rd_fire),
    .rd_last   (head[0]),
    .wr_idx    (wr_idx),
    .rd_idx    (rd_idx),
    .count     (count),
    .pkt_count (pkt_count)
  );

  // Next storage contents: only the addressed row changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_fire) mem_d[wr_idx] = {bus.data_in, bus.data_in_last};
  end

  // Storage register; reset clears every row so the output reads zero.
  always_ff @(posedge clk) begin
    if (sync_rst) mem_q <= '{default: '0};
    else          mem_q <= mem_d;
  end

  assign bus.data_in_ready  = in_ready;
  assign bus.data_out_valid = out_valid;
  assign bus.data_out       = head[DATA_W:1];
  assign bus.data_out_last  = head[0];

  assign status_count     = count;
  assign status_pkt_count = pkt_count;
  assign status_full      = (count == DEPTH_C);
  assign status_empty     = (count == '0);
  assign status_afull     = (count >= CNT_W'(AFULL_LVL));
  assign status_aempty    = (count <= CNT_W'(AEMPTY_LVL));

endmodule

// File: tb/tb_fifo_vr_pkt.sv
// Directed bench for fifo_vr_pkt: one cut-through and one
// store-and-forward instance, both DEPTH=4, DATA_W=16.
module tb_fifo_vr_pkt;
  import fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       ct_rst, ct_en, sf_rst, sf_en;
  logic [2:0] ct_cnt, ct_pc, sf_cnt, sf_pc;
  logic       ct_full, ct_empty, ct_afull, ct_aempty;
  logic       sf_full, sf_empty, sf_afull, sf_aempty;

  fifo_vr_pkt_if #(.DATA_W(16)) ct_if ();
  fifo_vr_pkt_if #(.DATA_W(16)) sf_if ();

  fifo_vr_pkt #(.DEPTH(4), .DATA_W(16), .PKT_MODE(0)) dut_ct (
    .clk(clk), .sync_rst(ct_rst), .en(ct_en), .bus(ct_if),
    .status_count(ct_cnt), .status_pkt_count(ct_pc),
    .status_full(ct_full), .status_empty(ct_empty),
    .status_afull(ct_afull), .status_aempty(ct_aempty)
  );

  fifo_vr_pkt #(.DEPTH(4), .DATA_W(16), .PKT_MODE(1)) dut_sf (
    .clk(clk), .sync_rst(sf_rst), .en(sf_en), .bus(sf_if),
    .status_count(sf_cnt), .status_pkt_count(sf_pc),
    .status_full(sf_full), .status_empty(sf_empty),
    .status_afull(sf_afull), .status_aempty(sf_aempty)
  );

  typedef struct {
    logic        sf, rst, en, vi;
    logic [15:0] di;
    logic        li, ro;
    logic        ir, ov, cd;
    logic [15:0] dout;
    logic        lo;
    logic [2:0]  cnt, pc;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic sf, rst, en, vi, input logic [15:0] di,
                              input logic li, ro, ir, ov, cd, input logic [15:0] dout,
                              input logic lo, input logic [2:0] cnt, pc);
    vec_t v;
    v.sf = sf; v.rst = rst; v.en = en; v.vi = vi; v.di = di; v.li = li; v.ro = ro;
    v.ir = ir; v.ov = ov; v.cd = cd; v.dout = dout; v.lo = lo; v.cnt = cnt; v.pc = pc;
    vq.push_back(v);
  endfunction

  task automatic drive_ct(input logic rst, en, vi, input logic [15:0] di, input logic li, ro);
    ct_rst = rst; ct_en = en; ct_if.data_in_valid = vi; ct_if.data_in = di;
    ct_if.data_in_last = li; ct_if.data_out_ready = ro;
  endtask

  task automatic drive_sf(input logic rst, en, vi, input logic [15:0] di, input logic li, ro);
    sf_rst = rst; sf_en = en; sf_if.data_in_valid = vi; sf_if.data_in = di;
    sf_if.data_in_last = li; sf_if.data_out_ready = ro;
  endtask

  // Drive one vector at the falling edge, check pre-edge outputs, let the rising edge act.
  task automatic apply(input int i, input vec_t v);
    logic       ir, ov, lo, full, empty, afull, aempty;
    logic [15:0] d;
    logic [2:0] cnt, pc;
    @(negedge clk);
    if (v.sf) begin
      drive_ct(0, 1, 0, 16'h0, 0, 0);
      drive_sf(v.rst, v.en, v.vi, v.di, v.li, v.ro);
    end else begin
      drive_sf(0, 1, 0, 16'h0, 0, 0);
      drive_ct(v.rst, v.en, v.vi, v.di, v.li, v.ro);
    end
    #1;
    ir = v.sf ? sf_if.data_in_ready : ct_if.data_in_ready;
    ov = v.sf ? sf_if.data_out_valid : ct_if.data_out_valid;
    d  = v.sf ? sf_if.data_out : ct_if.data_out;
    lo = v.sf ? sf_if.data_out_last : ct_if.data_out_last;
    cnt = v.sf ? sf_cnt : ct_cnt;
    pc  = v.sf ? sf_pc : ct_pc;
    full = v.sf ? sf_full : ct_full;
    empty = v.sf ? sf_empty : ct_empty;
    afull = v.sf ? sf_afull : ct_afull;
    aempty = v.sf ? sf_aempty : ct_aempty;
    chk($sformatf("row%0d.ready", i), 32'(ir), 32'(v.ir));
    chk($sformatf("row%0d.valid", i), 32'(ov), 32'(v.ov));
    if (v.cd) begin
      chk($sformatf("row%0d.data", i), 32'(d), 32'(v.dout));
      chk($sformatf("row%0d.last", i), 32'(lo), 32'(v.lo));
    end
    chk($sformatf("row%0d.count", i), 32'(cnt), 32'(v.cnt));
    chk($sformatf("row%0d.pkt_count", i), 32'(pc), 32'(v.pc));
    chk($sformatf("row%0d.full", i), 32'(full), 32'(v.cnt == 3'd4));
    chk($sformatf("row%0d.empty", i), 32'(empty), 32'(v.cnt == 3'd0));
    chk($sformatf("row%0d.afull", i), 32'(afull), 32'(v.cnt >= 3'd3));
    chk($sformatf("row%0d.aempty", i), 32'(aempty), 32'(v.cnt <= 3'd1));
  endtask

  initial begin
    int          widx, ridx;
    logic        seen_full, wf, rf;
    logic [15:0] exp_d;

    drive_ct(1, 1, 0, 16'h0, 0, 0);
    drive_sf(1, 1, 0, 16'h0, 0, 0);
    repeat (2) @(posedge clk);

    // Cut-through: reset state, fill past full, drain in order.
    add(0,0,1,0,16'h00,0,0, 1,0,1,16'h00,0,0,0);
    add(0,0,1,1,16'h11,0,0, 1,0,1,16'h00,0,0,0);
    add(0,0,1,1,16'h22,0,0, 1,1,1,16'h11,0,1,0);
    add(0,0,1,1,16'h33,1,0, 1,1,1,16'h11,0,2,0);
    add(0,0,1,1,16'h44,0,0, 1,1,1,16'h11,0,3,1);
    add(0,0,1,1,16'h55,0,0, 0,1,1,16'h11,0,4,1);
    add(0,0,1,0,16'h00,0,0, 0,1,1,16'h11,0,4,1);
    add(0,0,1,0,16'h00,0,1, 0,1,1,16'h11,0,4,1);
    add(0,0,1,0,16'h00,0,1, 1,1,1,16'h22,0,3,1);
    add(0,0,1,0,16'h00,0,1, 1,1,1,16'h33,1,2,1);
    add(0,0,1,0,16'h00,0,1, 1,1,1,16'h44,0,1,0);
    add(0,0,1,0,16'h00,0,0, 1,0,1,16'h11,0,0,0);
    // Refill, then write+read while full: write must be refused.
    add(0,0,1,1,16'hA0,0,0, 1,0,0,16'h00,0,0,0);
    add(0,0,1,1,16'hA1,0,0, 1,1,1,16'hA0,0,1,0);
    add(0,0,1,1,16'hA2,0,0, 1,1,1,16'hA0,0,2,0);
    add(0,0,1,1,16'hA3,0,0, 1,1,1,16'hA0,0,3,0);
    add(0,0,1,1,16'hB0,0,1, 0,1,1,16'hA0,0,4,0);
    add(0,0,1,0,16'h00,0,0, 1,1,1,16'hA1,0,3,0);
    add(0,0,1,0,16'h00,0,1, 1,1,1,16'hA1,0,3,0);
    // Concurrent write and read at count 2 for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      exp_d = (k == 0) ? 16'hA2 : (k == 1) ? 16'hA3 : 16'(16'hC0 + k - 2);
      add(0,0,1,1,16'(16'hC0 + k),0,1, 1,1,1,exp_d,0,2,0);
    end
    // Enable low at count 2: handshakes blocked, state held.
    add(0,0,0,1,16'hD0,0,1, 0,0,1,16'hC8,0,2,0);
    add(0,0,0,0,16'h00,0,0, 0,0,1,16'hC8,0,2,0);
    add(0,0,1,0,16'h00,0,1, 1,1,1,16'hC8,0,2,0);
    add(0,0,1,0,16'h00,0,1, 1,1,1,16'hC9,0,1,0);
    add(0,0,1,0,16'h00,0,0, 1,0,0,16'h00,0,0,0);
    // Store-and-forward: 3-word packet held until its last word lands.
    add(1,0,1,0,16'h000,0,0, 1,0,1,16'h000,0,0,0);
    add(1,0,1,1,16'h301,0,0, 1,0,1,16'h000,0,0,0);
    add(1,0,1,1,16'h302,0,0, 1,0,1,16'h301,0,1,0);
    add(1,0,1,1,16'h303,1,0, 1,0,1,16'h301,0,2,0);
    add(1,0,1,0,16'h000,0,0, 1,1,1,16'h301,0,3,1);
    add(1,0,1,0,16'h000,0,1, 1,1,1,16'h301,0,3,1);
    add(1,0,1,0,16'h000,0,1, 1,1,1,16'h302,0,2,1);
    add(1,0,1,0,16'h000,0,1, 1,1,1,16'h303,1,1,1);
    add(1,0,1,0,16'h000,0,0, 1,0,0,16'h000,0,0,0);
    // Packet completes while another leaves: pkt_count unchanged.
    add(1,0,1,1,16'h311,1,0, 1,0,0,16'h000,0,0,0);
    add(1,0,1,1,16'h312,1,1, 1,1,1,16'h311,1,1,1);
    add(1,0,1,0,16'h000,0,0, 1,1,1,16'h312,1,1,1);
    add(1,0,1,0,16'h000,0,1, 1,1,1,16'h312,1,1,1);
    add(1,0,1,0,16'h000,0,0, 1,0,0,16'h000,0,0,0);

    foreach (vq[i]) apply(i, vq[i]);

    // Oversize 6-word packet: held until full, then streams through.
    drive_ct(0, 1, 0, 16'h0, 0, 0);
    widx = 0; ridx = 0; seen_full = 0;
    for (int cyc = 0; cyc < 40 && ridx < 6; cyc++) begin
      @(negedge clk);
      drive_sf(0, 1, widx < 6, 16'(16'h0E0 + widx), widx == 5, seen_full);
      #1;
      if (!seen_full && widx < 4) chk("ovs.held", 32'(sf_if.data_out_valid), 32'd0);
      if (!seen_full && widx == 4) begin
        chk("ovs.valid_at_full", 32'(sf_if.data_out_valid), 32'd1);
        chk("ovs.count_at_full", 32'(sf_cnt), 32'd4);
        chk("ovs.ready_at_full", 32'(sf_if.data_in_ready), 32'd0);
        seen_full = 1;
        sf_if.data_out_ready = 1'b1;
        #1;
      end
      wf = sf_if.data_in_valid && sf_if.data_in_ready;
      rf = sf_if.data_out_valid && sf_if.data_out_ready;
      if (rf) begin
        chk($sformatf("ovs.word%0d", ridx), 32'(sf_if.data_out), 32'(16'h0E0 + ridx));
        chk($sformatf("ovs.last%0d", ridx), 32'(sf_if.data_out_last), 32'(ridx == 5));
        ridx++;
      end
      if (wf) widx++;
    end
    chk("ovs.words_out", 32'(ridx), 32'd6);
    @(negedge clk);
    drive_sf(0, 1, 0, 16'h0, 0, 0);
    #1;
    chk("ovs.pkt_count_end", 32'(sf_pc), 32'd0);
    chk("ovs.count_end", 32'(sf_cnt), 32'd0);

    // Reset in the middle of a packet discards it and clears storage.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_sf(0, 1, 1, 16'(16'h0F0 + k), 0, 0);
    end
    @(negedge clk);
    drive_sf(1, 1, 1, 16'h0F3, 0, 1);
    #1;
    chk("rst.count_before", 32'(sf_cnt), 32'd3);
    @(negedge clk);
    drive_sf(0, 1, 0, 16'h0, 0, 0);
    #1;
    chk("rst.count", 32'(sf_cnt), 32'd0);
    chk("rst.valid", 32'(sf_if.data_out_valid), 32'd0);
    chk("rst.pkt_count", 32'(sf_pc), 32'd0);
    chk("rst.data", 32'(sf_if.data_out), 32'd0);
    chk("rst.ready", 32'(sf_if.data_in_ready), 32'd1);
    @(negedge clk);
    drive_sf(0, 1, 1, 16'h05A, 1, 0);
    @(negedge clk);
    drive_sf(0, 1, 0, 16'h0, 0, 0);
    #1;
    chk("post.valid", 32'(sf_if.data_out_valid), 32'd1);
    chk("post.data", 32'(sf_if.data_out), 32'h5A);
    chk("post.last", 32'(sf_if.data_out_last), 32'd1);
    chk("post.pkt_count", 32'(sf_pc), 32'd1);
    sf_if.data_out_ready = 1'b1;
    @(negedge clk);
    drive_sf(0, 1, 0, 16'h0, 0, 0);
    #1;
    chk("post.count_end", 32'(sf_cnt), 32'd0);
    chk("post.pkt_count_end", 32'(sf_pc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
